parity_frame_rx: RTL
====================

# parity_frame_rx

Serial receiver and parity checker for the even-parity byte frames produced by the team's parity generator. It samples a one-wire serial line at a bit-rate strobe and reassembles each frame (start bit, DATA_W data bits LSB first, parity bit, stop bit). It presents the parallel word with a one-cycle valid pulse and parity/framing error flags. It sits between the line interface and the consuming logic, and can optionally keep a saturating error count.

## Interface
- DATA_W, 8, number of data bits per frame (≥1)
- CNT_W, 8, width of the error counter (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- bit_en  input  1  one-cycle bit-rate strobe; rx_in is sampled only on cycles where bit_en=1
- rx_in  input  1  serial line, idles high
- err_clr  input  1  synchronous clear of err_count
- data_out  output  DATA_W  last received data word
- data_valid  output  1  one-cycle pulse: a frame has completed
- parity_err  output  1  parity mismatch on the completed frame; valid with data_valid
- frame_err  output  1  stop bit was 0 on the completed frame; valid with data_valid
- busy  output  1  high while a frame is in progress (state ≠ IDLE)
- err_count  output  CNT_W  count of errored frames (see Configuration)

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on clock edges where bit_en=1. With bit_en=0 the state, bit counter and shift register hold.
- IDLE:
  - rx_in=0 (start bit) → DATA; bit counter←0; running parity←0.
  - rx_in=1 → stay in IDLE.
- DATA:
  - Shift rx_in in LSB first; running parity ^= rx_in; counter increments.
  - After the DATA_W-th bit → PARITY.
- PARITY:
  - Capture the parity bit; error = running parity ^ rx_in (even parity, so a correct frame gives 0) → STOP.
- STOP:
  - Sample the stop bit → IDLE.
  - Register outputs: data_out←assembled word; parity_err←parity error; frame_err←(rx_in==0); data_valid←1.
- Frames with errors still assert data_valid and update data_out.
- data_out holds until the next completed frame. data_valid, parity_err and frame_err are all cleared on the next clock edge.
- There is no glitch or false-start filtering. A 0 sampled in IDLE always starts a frame.
- Error counter:
  - Increments by 1 per completed frame with parity_err or frame_err set. A frame with both errors counts once.
  - Saturates at 2^CNT_W−1.
  - err_clr=1 clears the counter to 0. If err_clr and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Reset values: state IDLE; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0; err_count=0.
- Frame length is DATA_W+3 bit_en strobes.
- data_valid and the flags are high for exactly one clk cycle: the cycle after the clock edge that sampled the stop bit.
- busy rises in the cycle after the start-bit sample. It falls in the same cycle that data_valid rises.
- Back-to-back frames: the strobe after the stop bit may carry the next start bit. No idle bit is required.
- Reset asserted mid-frame: everything returns immediately to reset values and the partial frame is discarded, with no data_valid pulse. After reset deasserts, reception resumes from IDLE.
- err_count updates in the same cycle data_valid is asserted.

## Configuration
- PARITY_RX_ERR_CNT_EN defined:
  - The saturating error counter and err_clr are implemented as described.
- PARITY_RX_ERR_CNT_EN undefined:
  - No counter logic is present; err_count is tied to 0 and err_clr is ignored.
  - All other behaviour is identical.

## Test plan
- Good frame: send 0xA5 (four ones) with parity bit 0 and stop bit 1 → data_out=0xA5, one-cycle data_valid, parity_err=0, frame_err=0, err_count unchanged.
- Parity error: send 0xA5 with parity bit 1 → data_valid, parity_err=1, frame_err=0, err_count=1 (macro on) / 0 (macro off).
- Framing error plus back-to-back: send 0x3C, parity bit 0, stop bit 0, then immediately 0x01 with parity bit 1 and stop bit 1.
  - First frame: frame_err=1, parity_err=0.
  - Second frame: data_out=0x01, no errors.
  - Exactly two data_valid pulses in total.
- Reset mid-frame: assert reset after 4 data bits of 0xFF → all outputs 0, no data_valid. Then send 0x80 with parity bit 1 → data_out=0x80 with no errors.
- Counter saturation and clear, with CNT_W=2 and the macro on:
  - Send 4 parity-error frames → err_count sequence 1, 2, 3, 3.
  - Assert err_clr in the same cycle as a 5th errored frame's data_valid → err_count=0.
- Strobe gating: hold bit_en=0 for 20 cycles mid-frame while toggling rx_in → state and shift register unchanged, and the frame completes correctly once strobes resume.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
// -----------------------------------------------------------------------------
// parity_frame_rx_if
//
// Bundles the serial-line side and the parallel result side of the
// parity_frame_rx receiver.
//
//   bit_en     : one-cycle bit-rate strobe
//   rx_in      : serial line, idles high
//   err_clr    : synchronous clear of the error counter
//   data_out   : last received data word
//   data_valid : one-cycle pulse when a frame completes
//   parity_err : parity mismatch on the completed frame
//   frame_err  : stop bit sampled as 0 on the completed frame
//   busy       : a frame is in progress
//   err_count  : saturating count of errored frames
//
// Modports:
//   slave  - the receiver (consumes line signals, drives results)
//   master - the environment (drives line signals, consumes results)
// -----------------------------------------------------------------------------
interface parity_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              bit_en;
  logic              rx_in;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport slave (
    input  bit_en,
    input  rx_in,
    input  err_clr,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy,
    output err_count
  );

  modport master (
    output bit_en,
    output rx_in,
    output err_clr,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy,
    input  err_count
  );

endinterface

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
//
// Serial receiver and even-parity checker. Frames are: start bit (0),
// DATA_W data bits LSB first, one even-parity bit, one stop bit (1).
// The line is sampled only on cycles where bus.bit_en is high; with the
// strobe low the FSM, bit counter and shift register hold.
//
// On the strobe that samples the stop bit the assembled word and the two
// error flags are registered and data_valid pulses for one clock. Errored
// frames are still delivered.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : parity_frame_rx_if.slave (see interface for signal list)
//
// Parameters:
//   DATA_W : data bits per frame (>= 1)
//   CNT_W  : width of the error counter (>= 1)
//
// Build option:
//   PARITY_RX_ERR_CNT_EN - when defined, a saturating count of errored
//   frames is kept on err_count and err_clr clears it (clear wins over a
//   simultaneous increment). When undefined, err_count is tied to 0 and
//   err_clr is ignored.
// -----------------------------------------------------------------------------
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  parity_frame_rx_if.slave  bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;     // running XOR of data bits
  logic              perr_q, perr_d;   // parity result held through STOP

  // Registered frame result (one stage after the stop-bit sample)
  logic [DATA_W-1:0] data_p1, data_d;
  logic              vld_p1, vld_d;
  logic              perr_p1, perr_out_d;
  logic              ferr_p1, ferr_out_d;

  // ---------------------------------------------------------------------------
  // Next-state / datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    data_d     = data_p1;
    vld_d      = 1'b0;
    perr_out_d = 1'b0;
    ferr_out_d = 1'b0;

    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          // No false-start filtering: any 0 in IDLE begins a frame.
          if (!bus.rx_in) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end

        DATA: begin
          // Write by position rather than shifting so any DATA_W works.
          shift_d[cnt_q] = bus.rx_in;
          par_d          = par_q ^ bus.rx_in;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end

        PARITY: begin
          // Even parity: a good frame XORs to zero.
          perr_d  = par_q ^ bus.rx_in;
          state_d = STOP;
        end

        STOP: begin
          state_d    = IDLE;
          data_d     = shift_q;
          vld_d      = 1'b1;
          perr_out_d = perr_q;
          ferr_out_d = ~bus.rx_in;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: FSM state, frame assembly and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
      ferr_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      data_p1 <= data_d;
      vld_p1  <= vld_d;
      perr_p1 <= perr_out_d;
      ferr_p1 <= ferr_out_d;
    end
  end

  assign bus.data_out   = data_p1;
  assign bus.data_valid = vld_p1;
  assign bus.parity_err = perr_p1;
  assign bus.frame_err  = ferr_p1;
  assign bus.busy       = (state_q != IDLE);

`ifdef PARITY_RX_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Error counter: steps on the same edge that raises data_valid, so the
  // new count is visible alongside the pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (vld_d && (perr_out_d || ferr_out_d)) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = bus.err_clr;
  assign bus.err_count  = '0;
`endif

endmodule
